// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer: widths, function codes,
// ALU op codes, FSM states and the function-to-control encoder.
package alu_seq_pkg;

    localparam int unsigned W      = 16;
    localparam int unsigned FUNC_W = 4;
    localparam int unsigned OP_W   = 3;

    localparam logic [FUNC_W-1:0] F_AND = 4'd0;
    localparam logic [FUNC_W-1:0] F_OR  = 4'd1;
    localparam logic [FUNC_W-1:0] F_XOR = 4'd2;
    localparam logic [FUNC_W-1:0] F_ADD = 4'd3;
    localparam logic [FUNC_W-1:0] F_SUB = 4'd4;
    localparam logic [FUNC_W-1:0] F_ADC = 4'd5;
    localparam logic [FUNC_W-1:0] F_SBB = 4'd6;
    localparam logic [FUNC_W-1:0] F_SLL = 4'd7;
    localparam logic [FUNC_W-1:0] F_SRL = 4'd8;
    localparam logic [FUNC_W-1:0] F_MUL = 4'd9;
    localparam logic [FUNC_W-1:0] F_SLT = 4'd10;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_SLL = 3'b001;
    localparam logic [OP_W-1:0] OP_OR  = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD = 3'b100;
    localparam logic [OP_W-1:0] OP_SRL = 3'b110;
    localparam logic [OP_W-1:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic            cin;
        logic            bnegate;
    } alu_ctrl_t;

    function automatic logic is_legal(input logic [FUNC_W-1:0] func);
        return func <= F_SLT;
    endfunction

    // Codes that write the carry flag from the ALU carry-out.
    function automatic logic is_arith(input logic [FUNC_W-1:0] func);
        return (func >= F_ADD) && (func <= F_SBB);
    endfunction

    function automatic logic has_ovf(input logic [FUNC_W-1:0] func);
        return is_arith(func) || (func == F_SLT);
    endfunction

    function automatic alu_ctrl_t encode(input logic [FUNC_W-1:0] func,
                                         input logic              carry_flag);
        alu_ctrl_t c;
        c = '{op: OP_AND, cin: 1'b0, bnegate: 1'b0};
        case (func)
            F_AND: c.op = OP_AND;
            F_OR:  c.op = OP_OR;
            F_XOR: c.op = OP_XOR;
            F_ADD: c.op = OP_ADD;
            F_SUB: c = '{op: OP_ADD, cin: 1'b1, bnegate: 1'b1};
            F_ADC: c = '{op: OP_ADD, cin: carry_flag, bnegate: 1'b0};
            F_SBB: c = '{op: OP_ADD, cin: carry_flag, bnegate: 1'b1};
            F_SLL: c.op = OP_SLL;
            F_SRL: c.op = OP_SRL;
            F_MUL: c.op = OP_MUL;
            F_SLT: c = '{op: OP_ADD, cin: 1'b1, bnegate: 1'b1};
            default: c = '{op: OP_AND, cin: 1'b0, bnegate: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational result/flag derivation from the ALU outputs of the command
// currently in EXEC. 'carry' is the updated carry flag value.
module alu_flag_calc
    import alu_seq_pkg::*;
(
    input  logic [FUNC_W-1:0] func,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b_eff,
    input  logic [W-1:0]      rez,
    input  logic              cout,
    input  logic              carry_flag,
    output logic [W-1:0]      data,
    output logic              carry,
    output logic              zero,
    output logic              neg,
    output logic              ovf,
    output logic              err
);

    always_comb begin
        err   = !is_legal(func);
        ovf   = has_ovf(func) && (a[W-1] == b_eff[W-1]) && (rez[W-1] != a[W-1]);
        carry = is_arith(func) ? cout : carry_flag;
        data  = rez;
        // SLT reports the true sign of a-b, corrected for overflow.
        if (func == F_SLT) begin
            data    = '0;
            data[0] = rez[W-1] ^ ovf;
        end
        if (err) begin
            data = '0;
        end
        zero = !err && (data == '0);
        neg  = data[W-1];
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accepts ALU commands, drives the external ALU, tracks a carry flag across
// commands and returns result plus status flags over a valid/ready port.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [FUNC_W-1:0] cmd_func,
    input  logic [W-1:0]      cmd_a,
    input  logic [W-1:0]      cmd_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic              alu_cin,
    output logic              alu_bnegate,
    input  logic [W-1:0]      alu_rezultati,
    input  logic              alu_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_data,
    output logic              res_carry,
    output logic              res_zero,
    output logic              res_neg,
    output logic              res_ovf,
    output logic              res_err
);

    state_t            state;
    state_t            state_nxt;
    logic [FUNC_W-1:0] func_q;
    logic              carry_flag;
    logic              accept;
    alu_ctrl_t         ctrl_nxt;
    logic [W-1:0]      b_eff;
    logic [W-1:0]      flg_data;
    logic              flg_carry;
    logic              flg_zero;
    logic              flg_neg;
    logic              flg_ovf;
    logic              flg_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (res_ready) state_nxt = cmd_valid ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // In RESP a new command is taken only in the cycle the result is consumed.
    always_comb begin
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: cmd_ready = 1'b1;
            RESP: begin
                res_valid = 1'b1;
                cmd_ready = res_ready;
            end
            default: ;
        endcase
    end

    assign accept   = cmd_valid && cmd_ready;
    assign ctrl_nxt = encode(cmd_func, carry_flag);
    assign b_eff    = alu_bnegate ? ~alu_b : alu_b;

    alu_flag_calc u_flag_calc (
        .func       (func_q),
        .a          (alu_a),
        .b_eff      (b_eff),
        .rez        (alu_rezultati),
        .cout       (alu_cout),
        .carry_flag (carry_flag),
        .data       (flg_data),
        .carry      (flg_carry),
        .zero       (flg_zero),
        .neg        (flg_neg),
        .ovf        (flg_ovf),
        .err        (flg_err)
    );

    // Illegal codes leave the ALU drive untouched; only func_q records them.
    always_ff @(posedge clk) begin
        if (reset) begin
            func_q      <= '0;
            carry_flag  <= 1'b0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_cin     <= 1'b0;
            alu_bnegate <= 1'b0;
            res_data    <= '0;
            res_carry   <= 1'b0;
            res_zero    <= 1'b0;
            res_neg     <= 1'b0;
            res_ovf     <= 1'b0;
            res_err     <= 1'b0;
        end else begin
            if (accept) begin
                func_q <= cmd_func;
                if (is_legal(cmd_func)) begin
                    alu_op      <= ctrl_nxt.op;
                    alu_a       <= cmd_a;
                    alu_b       <= cmd_b;
                    alu_cin     <= ctrl_nxt.cin;
                    alu_bnegate <= ctrl_nxt.bnegate;
                end
            end
            if (state == EXEC) begin
                carry_flag <= flg_carry;
                res_data   <= flg_data;
                res_carry  <= flg_carry && !flg_err;
                res_zero   <= flg_zero;
                res_neg    <= flg_neg;
                res_ovf    <= flg_ovf;
                res_err    <= flg_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU, arithmetic reference model,
// directed scenarios followed by randomized commands.
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_func;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic        alu_bnegate;
    logic [15:0] alu_rezultati;
    logic        alu_cout;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_carry;
    logic        res_zero;
    logic        res_neg;
    logic        res_ovf;
    logic        res_err;

    int   n_cmp;
    int   n_err;
    logic ref_carry;

    typedef struct {
        logic [15:0] data;
        logic        carry;
        logic        zero;
        logic        neg;
        logic        ovf;
        logic        err;
        logic        newc;
        logic [2:0]  op;
        logic        cin;
        logic        bneg;
    } exp_t;

    alu_cmd_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_func      (cmd_func),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_cin       (alu_cin),
        .alu_bnegate   (alu_bnegate),
        .alu_rezultati (alu_rezultati),
        .alu_cout      (alu_cout),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_carry     (res_carry),
        .res_zero      (res_zero),
        .res_neg       (res_neg),
        .res_ovf       (res_ovf),
        .res_err       (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the external 16-bit ALU.
    logic [15:0] alu_beff;
    logic [16:0] alu_sum;
    always_comb begin
        alu_beff      = alu_bnegate ? ~alu_b : alu_b;
        alu_sum       = {1'b0, alu_a} + {1'b0, alu_beff} + 17'(alu_cin);
        alu_rezultati = 16'h0000;
        alu_cout      = 1'b0;
        case (alu_op)
            3'b000: alu_rezultati = alu_a & alu_beff;
            3'b010: alu_rezultati = alu_a | alu_beff;
            3'b011: alu_rezultati = alu_a ^ alu_beff;
            3'b100: begin
                alu_rezultati = alu_sum[15:0];
                alu_cout      = alu_sum[16];
            end
            3'b001: alu_rezultati = alu_a << alu_beff[3:0];
            3'b110: alu_rezultati = alu_a >> alu_beff[3:0];
            3'b111: alu_rezultati = 16'(alu_a * alu_beff);
            default: alu_rezultati = 16'h0000;
        endcase
    end

    function automatic logic out_of_range(input longint v);
        return (v > 32767) || (v < -32768);
    endfunction

    // Reference: result and flags straight from integer arithmetic.
    function automatic exp_t model(input int f, input int a, input int b, input logic c);
        exp_t   e;
        longint r, sa, sb, ci;
        ci     = c ? 1 : 0;
        sa     = (a >= 32768) ? longint'(a) - 65536 : longint'(a);
        sb     = (b >= 32768) ? longint'(b) - 65536 : longint'(b);
        r      = 0;
        e.err  = 1'b0;
        e.newc = c;
        e.ovf  = 1'b0;
        e.op   = 3'b000;
        e.cin  = 1'b0;
        e.bneg = 1'b0;
        case (f)
            0: r = a & b;
            1: begin r = a | b; e.op = 3'b010; end
            2: begin r = a ^ b; e.op = 3'b011; end
            3: begin
                r = longint'(a) + b; e.newc = (r > 65535);
                e.ovf = out_of_range(sa + sb); e.op = 3'b100;
            end
            4: begin
                r = longint'(a) - b; e.newc = (r >= 0);
                e.ovf = out_of_range(sa - sb); e.op = 3'b100; e.cin = 1'b1; e.bneg = 1'b1;
            end
            5: begin
                r = longint'(a) + b + ci; e.newc = (r > 65535);
                e.ovf = out_of_range(sa + sb + ci); e.op = 3'b100; e.cin = c;
            end
            6: begin
                r = longint'(a) - b - (1 - ci); e.newc = (r >= 0);
                e.ovf = out_of_range(sa - sb - (1 - ci)); e.op = 3'b100; e.cin = c; e.bneg = 1'b1;
            end
            7: begin r = longint'(a) << (b % 16); e.op = 3'b001; end
            8: begin r = longint'(a) >> (b % 16); e.op = 3'b110; end
            9: begin r = longint'(a) * longint'(b); e.op = 3'b111; end
            10: begin
                r = (sa < sb) ? 1 : 0;
                e.ovf = out_of_range(sa - sb); e.op = 3'b100; e.cin = 1'b1; e.bneg = 1'b1;
            end
            default: begin r = 0; e.err = 1'b1; end
        endcase
        e.data  = 16'(r);
        e.carry = e.err ? 1'b0 : e.newc;
        e.zero  = !e.err && (e.data == 16'h0000);
        e.neg   = e.data[15];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // Present a command (from IDLE or RESP) and let it be accepted.
    task automatic issue(input int f, input int a, input int b);
        cmd_valid = 1'b1;
        cmd_func  = 4'(f);
        cmd_a     = 16'(a);
        cmd_b     = 16'(b);
        res_ready = 1'b1;
        #1;
        chk("cmd_ready_at_issue", 40'(cmd_ready), 40'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        chk("res_valid_in_exec", 40'(res_valid), 40'd0);
        chk("cmd_ready_in_exec", 40'(cmd_ready), 40'd0);
    endtask

    task automatic do_cmd(input int f, input int a, input int b);
        exp_t        e;
        logic [39:0] ctrl_prev;
        logic [39:0] opnd_prev;
        e         = model(f, a, b, ref_carry);
        ctrl_prev = 40'({alu_op, alu_cin, alu_bnegate});
        opnd_prev = 40'({alu_a, alu_b});
        issue(f, a, b);
        if (e.err) begin
            chk("alu_ctrl_held", 40'({alu_op, alu_cin, alu_bnegate}), ctrl_prev);
            chk("alu_opnd_held", 40'({alu_a, alu_b}), opnd_prev);
        end else begin
            chk("alu_ctrl", 40'({alu_op, alu_cin, alu_bnegate}), 40'({e.op, e.cin, e.bneg}));
            chk("alu_opnd", 40'({alu_a, alu_b}), 40'({16'(a), 16'(b)}));
        end
        @(posedge clk); #1;
        chk("res_valid_latency", 40'(res_valid), 40'd1);
        chk("res_data", 40'(res_data), 40'(e.data));
        chk("res_flags_cznoe", 40'({res_carry, res_zero, res_neg, res_ovf, res_err}),
            40'({e.carry, e.zero, e.neg, e.ovf, e.err}));
        chk("cmd_ready_resp_stalled", 40'(cmd_ready), 40'd0);
        ref_carry = e.newc;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("res_valid_after_drain", 40'(res_valid), 40'd0);
        chk("cmd_ready_idle", 40'(cmd_ready), 40'd1);
    endtask

    initial begin
        int edges[4];
        int f;
        int a;
        int b;
        edges     = '{0, 'hFFFF, 'h7FFF, 'h8000};
        n_cmp     = 0;
        n_err     = 0;
        ref_carry = 1'b0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_func  = 4'h0;
        cmd_a     = 16'h0000;
        cmd_b     = 16'h0000;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", 40'(cmd_ready), 40'd1);
        chk("reset_res_valid", 40'(res_valid), 40'd0);
        chk("reset_res", 40'({res_data, res_carry, res_zero, res_neg, res_ovf, res_err}), 40'd0);
        chk("reset_alu", 40'({alu_op, alu_cin, alu_bnegate, alu_a}), 40'd0);
        chk("reset_alu_b", 40'(alu_b), 40'd0);
        reset = 1'b0;

        do_cmd(3, 10, 6);
        drain();
        do_cmd(4, 1, 1);
        do_cmd(10, 'h0049, 'h0055);
        drain();

        do_cmd(3, 'hFFFF, 1);
        do_cmd(5, 0, 0);
        do_cmd(3, 'h7FFF, 1);
        drain();

        // MUL held under backpressure while the next command waits.
        do_cmd(9, 20, 10);
        cmd_valid = 1'b1;
        cmd_func  = 4'd3;
        cmd_a     = 16'd1;
        cmd_b     = 16'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_res_valid", 40'(res_valid), 40'd1);
            chk("hold_res_data", 40'(res_data), 40'd200);
            chk("hold_cmd_ready", 40'(cmd_ready), 40'd0);
        end
        do_cmd(3, 1, 2);
        drain();

        do_cmd(3, 'hFFFF, 1);
        do_cmd(12, 'h1234, 'h5678);
        do_cmd(5, 0, 0);
        drain();

        // Reset during EXEC drops the pending result and clears carry.
        do_cmd(3, 'hFFFF, 1);
        drain();
        issue(3, 'hFFFF, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        ref_carry = 1'b0;
        chk("rst_exec_res_valid", 40'(res_valid), 40'd0);
        chk("rst_exec_cmd_ready", 40'(cmd_ready), 40'd1);
        @(posedge clk); #1;
        chk("rst_exec_res_valid_late", 40'(res_valid), 40'd0);
        do_cmd(5, 0, 0);
        drain();

        for (int n = 0; n < 300; n++) begin
            f = int'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : int'($urandom_range(0, 'hFFFF));
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : int'($urandom_range(0, 'hFFFF));
            do_cmd(f, a, b);
            if ($urandom_range(0, 1) == 0) drain();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side controller that drives the 16-bit ALU (ports op, a, b, cin, bnegate → REZULTATI, cout). It accepts abstract ALU commands over a valid/ready port and encodes each one into ALU control signals. It tracks a carry flag across commands for multi-word arithmetic and returns result plus status flags over a second valid/ready port. It sits between the datapath control unit and the ALU instance; the ALU itself stays outside this block.

## Interface
- W, 16, operand/result width; must match the ALU.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_func  in  4  function code (see Operation).
- cmd_a, cmd_b  in  W  operands.
- alu_op  out  3  to ALU op.
- alu_a, alu_b  out  W  to ALU a, b.
- alu_cin, alu_bnegate  out  1  to ALU cin, bnegate.
- alu_rezultati  in  W  from ALU REZULTATI.
- alu_cout  in  1  from ALU cout.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  W  result word.
- res_carry, res_zero, res_neg, res_ovf, res_err  out  1  status flags.

## Operation
- Function codes map to {op, cin, bnegate}:
  - 0 AND → 000/0/0; 1 OR → 010/0/0; 2 XOR → 011/0/0.
  - 3 ADD → 100/0/0; 4 SUB → 100/1/1.
  - 5 ADC → 100/carry_flag/0; 6 SBB → 100/carry_flag/1 (carry = NOT borrow).
  - 7 SLL → 001; 8 SRL → 110; 9 MUL → 111 (low W bits); 10 SLT → 100/1/1.
- Codes 11–15 are illegal: no ALU capture, res_data=0, res_err=1, all other flags 0, carry_flag unchanged.
- Result capture: res_data = alu_rezultati, except SLT, where res_data = {W-1 zeros, rez[W-1] ^ ovf}.
- ovf is computed only for codes 3–6 and 10: with b_eff = bnegate ? ~b : b, ovf = (a[W-1]==b_eff[W-1]) && (rez[W-1]!=a[W-1]). ovf=0 for all other codes.
- carry_flag is updated from alu_cout by codes 3–6 only; every other code leaves it unchanged. res_carry reflects carry_flag after the update.
- res_zero = (res_data==0); res_neg = res_data[W-1].
- FSM states:
  - IDLE: cmd_ready=1. On a handshake, register operands and controls, then go to EXEC.
  - EXEC: ALU outputs are stable. On the following edge, capture result and flags, then go to RESP.
  - RESP: res_valid=1; cmd_ready=res_ready.
    - res_ready=1 with cmd_valid=1: accept the new command → EXEC (back-to-back).
    - res_ready=1 with cmd_valid=0: → IDLE.
    - res_ready=0: hold all res_* outputs stable.
- alu_* outputs are registered and hold the last command's values until the next accept.

## Timing
- Reset value of every output is 0 except cmd_ready=1. State=IDLE, carry_flag=0.
- Latency: handshake at edge N → EXEC during cycle N+1 → res_valid=1 from edge N+2.
- Throughput: one command per 2 cycles with back-to-back acceptance in RESP.
- ADC/SBB issued back-to-back use the carry_flag written by the immediately preceding capture. It is valid because the update occurs at the EXEC→RESP edge, before the next accept.
- Reset asserted in EXEC or RESP discards the pending result. No res_valid follows, and carry_flag clears.
- res_valid never drops without a res_ready handshake, except on reset.

## Structure
- Package alu_seq_pkg holds:
  - func code localparams (F_AND … F_SLT);
  - ALU op localparams (OP_AND=000, OP_SLL=001, OP_OR=010, OP_XOR=011, OP_ADD=100, OP_SRL=110, OP_MUL=111);
  - the state encoding IDLE/EXEC/RESP.
- One sub-module, alu_flag_calc: combinational. Inputs: func, a, b_eff, rez, cout, carry_flag. Outputs: data, carry, zero, neg, ovf, err.

## Test plan
- ADD a=10, b=6 → res_data=16, carry=0, zero=0, ovf=0; res_valid two edges after accept.
- SUB a=1, b=1 → res_data=0, zero=1, carry=1. Then SLT a=0x0049, b=0x0055 → res_data=1, carry still 1.
- ADD 0xFFFF+0x0001 → 0, carry=1. Then back-to-back ADC 0+0 → res_data=1, carry=0. Then ADD 0x7FFF+1 → 0x8000, ovf=1, neg=1.
- MUL a=20, b=10 → res_data=200. Hold res_ready=0 for 5 cycles → outputs stable and cmd_ready=0. Then release → accepted.
- func=12 → res_err=1, res_data=0, carry_flag unchanged, no alu_* change.
- Reset asserted during EXEC of ADD 0xFFFF+1 → no res_valid follows, carry_flag=0; the next ADC 0+0 returns 0.
